// File: rtl/hwpe_tcdm_flat_buffer.sv
// Per-port TCDM request buffer: DEPTH-entry request FIFO, outstanding limiter and status per master port.
// Optional stall counters are enabled by defining HWPE_TCDM_BUF_PERF_EN.
module hwpe_tcdm_flat_buffer #(
    parameter int unsigned MP      = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 8,
    localparam int unsigned BW     = DW / 8,
    localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    // engine side
    input  logic [MP-1:0]      in_req,
    output logic [MP-1:0]      in_gnt,
    input  logic [MP*AW-1:0]   in_add,
    input  logic [MP-1:0]      in_wen,
    input  logic [MP*BW-1:0]   in_be,
    input  logic [MP*DW-1:0]   in_data,
    output logic [MP*DW-1:0]   in_r_data,
    output logic [MP-1:0]      in_r_valid,
    // interconnect side
    output logic [MP-1:0]      tcdm_req,
    input  logic [MP-1:0]      tcdm_gnt,
    output logic [MP*AW-1:0]   tcdm_add,
    output logic [MP-1:0]      tcdm_wen,
    output logic [MP*BW-1:0]   tcdm_be,
    output logic [MP*DW-1:0]   tcdm_data,
    input  logic [MP*DW-1:0]   tcdm_r_data,
    input  logic [MP-1:0]      tcdm_r_valid,
    // status
    output logic [MP*LW-1:0]   level_o,
    output logic               busy_o,
    output logic [MP-1:0]      err_o,
    output logic [MP*32-1:0]   perf_stall_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } entry_t;

    logic [MP-1:0] w_busy;

    for (genvar i = 0; i < MP; i++) begin : g_port
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic [CW-1:0] r_out_cnt;
        logic          r_err;
        entry_t        r_mem [DEPTH];

        logic [PW-1:0] w_level;
        logic          w_empty;
        logic          w_full;
        logic          w_gnt;
        logic          w_push;
        logic          w_pop;
        logic          w_rvalid;
        entry_t        w_in;
        entry_t        w_head;

        // Pointers carry one extra wrap bit so a full FIFO differs from an empty one.
        assign w_level  = r_wptr - r_rptr;
        assign w_empty  = (r_wptr == r_rptr);
        assign w_full   = (r_wptr[IW-1:0] == r_rptr[IW-1:0]) && (r_wptr[IW] != r_rptr[IW]);
        assign w_gnt    = !w_full && ((32'(r_out_cnt) + 32'(w_level)) < 32'(MAX_OUT));
        assign w_push   = in_req[i] && w_gnt;
        assign w_pop    = !w_empty && tcdm_gnt[i];
        assign w_rvalid = tcdm_r_valid[i];

        assign w_in = '{
            add:  in_add[i*AW +: AW],
            wen:  in_wen[i],
            be:   in_be[i*BW +: BW],
            data: in_data[i*DW +: DW]
        };

        // NOTE: the storage array carries no reset; only the pointers define which entries are valid.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wptr[IW-1:0]] <= w_in;
            end
        end

        // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else if (clear_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
            end
        end

        // A response with nothing outstanding flags an error instead of underflowing.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_out_cnt <= '0;
                r_err     <= 1'b0;
            end else if (clear_i) begin
                r_out_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_pop && !w_rvalid) begin
                    r_out_cnt <= r_out_cnt + CW'(1);
                end else if (!w_pop && w_rvalid && (r_out_cnt != '0)) begin
                    r_out_cnt <= r_out_cnt - CW'(1);
                end
                if (w_rvalid && (r_out_cnt == '0)) begin
                    r_err <= 1'b1;
                end
            end
        end

        assign w_head = r_mem[r_rptr[IW-1:0]];

        assign in_gnt[i]              = w_gnt;
        assign tcdm_req[i]            = !w_empty;
        assign tcdm_add[i*AW +: AW]   = w_head.add;
        assign tcdm_wen[i]            = w_head.wen;
        assign tcdm_be[i*BW +: BW]    = w_head.be;
        assign tcdm_data[i*DW +: DW]  = w_head.data;

        assign in_r_valid[i]          = tcdm_r_valid[i];
        assign in_r_data[i*DW +: DW]  = tcdm_r_data[i*DW +: DW];

        assign level_o[i*LW +: LW]    = LW'(w_level);
        assign err_o[i]               = r_err;
        assign w_busy[i]              = !w_empty || (r_out_cnt != '0);

`ifdef HWPE_TCDM_BUF_PERF_EN
        logic [31:0] r_perf;
        logic        w_stall;

        assign w_stall = !w_empty && !tcdm_gnt[i];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_perf <= '0;
            end else if (clear_i) begin
                r_perf <= '0;
            end else if (w_stall && (r_perf != 32'hFFFF_FFFF)) begin
                r_perf <= r_perf + 32'd1;
            end
        end

        assign perf_stall_o[i*32 +: 32] = r_perf;
`else
        assign perf_stall_o[i*32 +: 32] = '0;
`endif
    end

    assign busy_o = |w_busy;

endmodule

// File: tb/tb_hwpe_tcdm_flat_buffer.sv
// Directed self-checking bench for hwpe_tcdm_flat_buffer (MP=2, DEPTH=4, MAX_OUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_hwpe_tcdm_flat_buffer;

    localparam int MP = 2, DW = 32, AW = 32, DEPTH = 4, MAX_OUT = 8;
    localparam int BW = DW / 8;
    localparam int LW = $clog2(DEPTH + 1);

    logic               clk_i, rst_ni, clear_i;
    logic [MP-1:0]      in_req, in_gnt, in_wen, in_r_valid;
    logic [MP*AW-1:0]   in_add;
    logic [MP*BW-1:0]   in_be;
    logic [MP*DW-1:0]   in_data, in_r_data;
    logic [MP-1:0]      tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [MP*AW-1:0]   tcdm_add;
    logic [MP*BW-1:0]   tcdm_be;
    logic [MP*DW-1:0]   tcdm_data, tcdm_r_data;
    logic [MP*LW-1:0]   level_o;
    logic               busy_o;
    logic [MP-1:0]      err_o;
    logic [MP*32-1:0]   perf_stall_o;

    hwpe_tcdm_flat_buffer #(
        .MP(MP), .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
        .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
        .tcdm_r_valid(tcdm_r_valid),
        .level_o(level_o), .busy_o(busy_o), .err_o(err_o), .perf_stall_o(perf_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int p, input logic req, input logic [AW-1:0] add,
                         input logic wen, input logic [DW-1:0] data);
        in_req[p]           = req;
        in_add[p*AW +: AW]  = add;
        in_wen[p]           = wen;
        in_be[p*BW +: BW]   = '1;
        in_data[p*DW +: DW] = data;
    endtask

    function automatic logic [31:0] t_add(input int p);
        return tcdm_add[p*AW +: AW];
    endfunction

    function automatic logic [31:0] t_data(input int p);
        return tcdm_data[p*DW +: DW];
    endfunction

    function automatic logic [31:0] lvl(input int p);
        return 32'(level_o[p*LW +: LW]);
    endfunction

    function automatic logic [31:0] perf(input int p);
        return perf_stall_o[p*32 +: 32];
    endfunction

    task automatic pulse_clear();
        clear_i = 1'b1;
        next_cycle();
        clear_i = 1'b0;
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, npop, npu, npo;
        logic [31:0] exp_perf;

        rst_ni = 1'b0; clear_i = 1'b0;
        in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;

        // Reset state
        #12;
        check("rst_tcdm_req", 32'(tcdm_req), 32'h0);
        check("rst_in_gnt",   32'(in_gnt),   32'h3);
        check("rst_busy",     32'(busy_o),   32'h0);
        check("rst_level",    32'(level_o),  32'h0);
        check("rst_err",      32'(err_o),    32'h0);
        check("rst_perf0",    perf(0),       32'h0);
        check("rst_perf1",    perf(1),       32'h0);
        rst_ni = 1'b1;
        next_cycle();

        // 1: back-to-back reads on port 0, response one cycle after each grant
        for (int c = 0; c < 7; c++) begin
            drive(0, c < 4, 32'h100 + 32'(4 * c), 1'b1, 32'h0);
            tcdm_gnt[0]         = 1'b1;
            tcdm_r_valid[0]     = (c >= 2 && c < 6);
            tcdm_r_data[0 +: 32] = 32'hA000 + 32'(c);
            settle();
            if (c == 0) check("t1_latency", 32'(tcdm_req[0]), 32'h0);
            if (c >= 1 && c <= 4) begin
                check("t1_req",  32'(tcdm_req[0]), 32'h1);
                check("t1_add",  t_add(0), 32'h100 + 32'(4 * (c - 1)));
            end
            check("t1_rvalid", 32'(in_r_valid[0]), 32'((c >= 2 && c < 6) ? 1 : 0));
            if (c >= 2 && c < 6) check("t1_rdata", in_r_data[0 +: 32], 32'hA000 + 32'(c));
            if (c == 5) check("t1_busy_hi", 32'(busy_o), 32'h1);
            if (c == 6) check("t1_busy_lo", 32'(busy_o), 32'h0);
            next_cycle();
        end
        in_req = '0; tcdm_gnt = '0; tcdm_r_valid = '0;

        // 2: port 1 fills with grant low, then drains in order
        np = 0; npop = 0;
        for (int c = 0; c < 30 && npop < 6; c++) begin
            drive(1, np < 6, 32'h200 + 32'(4 * np), 1'b0, 32'hD0 + 32'(np));
            tcdm_gnt[1] = (c >= 6);
            settle();
            if (c == 4) begin
                check("t2_accepts",   32'(np),          32'd4);
                check("t2_full_gnt",  32'(in_gnt[1]),   32'h0);
                check("t2_level",     lvl(1),           32'd4);
                check("t2_head",      t_add(1),         32'h200);
                check("t2_wen",       32'(tcdm_wen[1]), 32'h0);
            end
            if (c == 5) check("t2_head_hold", t_add(1), 32'h200);
            if (c == 6) check("t2_no_gnt_on_pop", 32'(in_gnt[1]), 32'h0);
            if (in_req[1] && in_gnt[1]) np++;
            if (tcdm_req[1] && tcdm_gnt[1]) begin
                check("t2_order_add",  t_add(1),  32'h200 + 32'(4 * npop));
                check("t2_order_data", t_data(1), 32'hD0 + 32'(npop));
                npop++;
            end
            next_cycle();
        end
        check("t2_pops", 32'(npop), 32'd6);
        in_req = '0; tcdm_gnt = '0;
        tcdm_r_valid[1] = 1'b1;
        repeat (6) next_cycle();
        tcdm_r_valid = '0;
        settle();
        check("t2_drain_busy", 32'(busy_o), 32'h0);
        check("t2_drain_err",  32'(err_o),  32'h0);

        // 3: outstanding limit on port 0
        npu = 0; npo = 0;
        tcdm_gnt[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            drive(0, 1'b1, 32'h300 + 32'(4 * c), 1'b1, 32'h0);
            settle();
            if (in_req[0] && in_gnt[0]) npu++;
            if (tcdm_req[0] && tcdm_gnt[0]) npo++;
            next_cycle();
        end
        in_req = '0;
        settle();
        check("t3_pushes",   32'(npu),       32'd8);
        check("t3_pops",     32'(npo),       32'd8);
        check("t3_gnt_low",  32'(in_gnt[0]), 32'h0);
        check("t3_level",    lvl(0),         32'd0);
        check("t3_busy",     32'(busy_o),    32'h1);
        for (int k = 0; k < 8; k++) begin
            tcdm_r_valid[0] = 1'b1;
            settle();
            if (k == 0) check("t3_gnt_held", 32'(in_gnt[0]), 32'h0);
            if (k == 1) check("t3_gnt_back", 32'(in_gnt[0]), 32'h1);
            next_cycle();
        end
        tcdm_r_valid = '0; tcdm_gnt = '0;
        settle();
        check("t3_idle_busy", 32'(busy_o), 32'h0);
        check("t3_idle_err",  32'(err_o),  32'h0);

        // 4: spurious response on port 0
        tcdm_r_valid = 2'b01;
        settle();
        check("t4_fwd", 32'(in_r_valid), 32'h1);
        next_cycle();
        tcdm_r_valid = '0;
        settle();
        check("t4_err",      32'(err_o),  32'h1);
        check("t4_no_under", 32'(busy_o), 32'h0);
        pulse_clear();
        check("t4_err_clr",  32'(err_o),  32'h0);

        // 5: clear with 3 queued and 2 outstanding on port 0
        for (int c = 0; c < 7; c++) begin
            drive(0, (c < 2) || (c >= 4), 32'h400 + 32'(4 * c), 1'b1, 32'h0);
            tcdm_gnt[0] = (c == 2 || c == 3);
            next_cycle();
        end
        drive(0, 1'b1, 32'h4FC, 1'b1, 32'h0);
        tcdm_gnt[0] = 1'b0;
        clear_i = 1'b1;
        settle();
        check("t5_level_pre", lvl(0),       32'd3);
        check("t5_busy_pre",  32'(busy_o),  32'h1);
        next_cycle();
        clear_i = 1'b0; in_req = '0;
        settle();
        check("t5_level", lvl(0),           32'd0);
        check("t5_req",   32'(tcdm_req),    32'h0);
        check("t5_busy",  32'(busy_o),      32'h0);
        check("t5_err0",  32'(err_o),       32'h0);
        for (int k = 0; k < 2; k++) begin
            tcdm_r_valid[0] = 1'b1;
            settle();
            check("t5_late_fwd", 32'(in_r_valid[0]), 32'h1);
            next_cycle();
        end
        tcdm_r_valid = '0;
        settle();
        check("t5_late_err", 32'(err_o), 32'h1);
        pulse_clear();

        // 6: stall counter on port 1
        drive(1, 1'b1, 32'h500, 1'b1, 32'h0);
        next_cycle();
        in_req = '0;
        repeat (10) next_cycle();
        settle();
`ifdef HWPE_TCDM_BUF_PERF_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        check("t6_perf1",     perf(1), exp_perf);
        check("t6_perf0",     perf(0), 32'h0);
        pulse_clear();
        check("t6_perf_clr",  perf(1),       32'h0);
        check("t6_req_clr",   32'(tcdm_req), 32'h0);
        check("t6_busy_clr",  32'(busy_o),   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
